// File: rtl/vga_sync_gen_if.sv
`default_nettype none
// ============================================================================
// Module   : vga_sync_gen_if
// Brief    : Pixel interface between the VGA timing generator, the renderer
//            and the monitor pins.
// Revision : 1.0 - initial release
// ============================================================================

interface vga_sync_gen_if;
    logic [10:0] x;
    logic [10:0] y;
    logic        pix_en;
    logic        frame_start;
    logic [7:0]  rgb_in;
    logic        video_on;
    logic        hsync;
    logic        vsync;
    logic [7:0]  rgb_out;

    // Timing generator side
    modport master (
        input  rgb_in,
        output x, y, pix_en, frame_start, video_on, hsync, vsync, rgb_out
    );

    // Renderer / pin consumer side
    modport slave (
        output rgb_in,
        input  x, y, pix_en, frame_start, video_on, hsync, vsync, rgb_out
    );
endinterface

`default_nettype wire

// File: rtl/vga_sync_gen.sv
`default_nettype none
// ============================================================================
// Module   : vga_sync_gen
// Brief    : VGA timing generator. Scans x/y, samples the renderer colour one
//            pixel later and drives rgb/hsync/vsync pins mutually aligned.
// Revision : 1.0 - initial release
// ============================================================================

module vga_sync_gen #(
    parameter int CLK_DIV   = 2,
    parameter int H_VISIBLE = 640,
    parameter int H_FRONT   = 16,
    parameter int H_SYNC    = 96,
    parameter int H_BACK    = 48,
    parameter int V_VISIBLE = 480,
    parameter int V_FRONT   = 10,
    parameter int V_SYNC    = 2,
    parameter int V_BACK    = 33
) (
    input  logic              clk,
    input  logic              rst_n,
    vga_sync_gen_if.master    bus
);

    localparam int c_h_total = H_VISIBLE + H_FRONT + H_SYNC + H_BACK;
    localparam int c_v_total = V_VISIBLE + V_FRONT + V_SYNC + V_BACK;
    localparam int c_div_w   = (CLK_DIV > 1) ? $clog2(CLK_DIV) : 1;

    localparam logic [c_div_w-1:0] c_div_last = c_div_w'(CLK_DIV - 1);
    localparam logic [10:0] c_x_last   = 11'(c_h_total - 1);
    localparam logic [10:0] c_y_last   = 11'(c_v_total - 1);
    localparam logic [10:0] c_h_vis    = 11'(H_VISIBLE);
    localparam logic [10:0] c_v_vis    = 11'(V_VISIBLE);
    localparam logic [10:0] c_hs_first = 11'(H_VISIBLE + H_FRONT);
    localparam logic [10:0] c_hs_last  = 11'(H_VISIBLE + H_FRONT + H_SYNC - 1);
    localparam logic [10:0] c_vs_first = 11'(V_VISIBLE + V_FRONT);
    localparam logic [10:0] c_vs_last  = 11'(V_VISIBLE + V_FRONT + V_SYNC - 1);

    logic [c_div_w-1:0] div_cnt_q, div_cnt_d;
    logic               pix_en_q, pix_en_d;
    logic [10:0]        x_q, x_d;
    logic [10:0]        y_q, y_d;
    logic               frame_start_q, frame_start_d;
    logic               video_on_q, video_on_d;
    logic               hsync_q, hsync_d;
    logic               vsync_q, vsync_d;
    logic [7:0]         rgb_out_q, rgb_out_d;

    logic               w_visible;
    logic               w_x_wrap;
    logic               w_y_wrap;

    assign w_visible = (x_q < c_h_vis) && (y_q < c_v_vis);
    assign w_x_wrap  = (x_q == c_x_last);
    assign w_y_wrap  = (y_q == c_y_last);

    always_comb begin
        div_cnt_d     = (div_cnt_q == c_div_last) ? '0 : div_cnt_q + 1'b1;
        // The strobe is a registered copy of the terminal count, so the
        // counters below move on the edge after it is seen high.
        pix_en_d      = (div_cnt_q == c_div_last);
        x_d           = x_q;
        y_d           = y_q;
        frame_start_d = 1'b0;
        video_on_d    = video_on_q;
        hsync_d       = hsync_q;
        vsync_d       = vsync_q;
        rgb_out_d     = rgb_out_q;

        if (pix_en_q) begin
            video_on_d = w_visible;
            rgb_out_d  = w_visible ? bus.rgb_in : 8'h00;
            hsync_d    = ~((x_q >= c_hs_first) && (x_q <= c_hs_last));
            vsync_d    = ~((y_q >= c_vs_first) && (y_q <= c_vs_last));

            if (w_x_wrap) begin
                x_d = '0;
                if (w_y_wrap) begin
                    y_d           = '0;
                    frame_start_d = 1'b1;
                end else begin
                    y_d = y_q + 11'd1;
                end
            end else begin
                x_d = x_q + 11'd1;
            end
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            div_cnt_q     <= '0;
            pix_en_q      <= 1'b0;
            x_q           <= '0;
            y_q           <= '0;
            frame_start_q <= 1'b0;
            video_on_q    <= 1'b0;
            hsync_q       <= 1'b1;
            vsync_q       <= 1'b1;
            rgb_out_q     <= 8'h00;
        end else begin
            div_cnt_q     <= div_cnt_d;
            pix_en_q      <= pix_en_d;
            x_q           <= x_d;
            y_q           <= y_d;
            frame_start_q <= frame_start_d;
            video_on_q    <= video_on_d;
            hsync_q       <= hsync_d;
            vsync_q       <= vsync_d;
            rgb_out_q     <= rgb_out_d;
        end
    end

    assign bus.x           = x_q;
    assign bus.y           = y_q;
    assign bus.pix_en      = pix_en_q;
    assign bus.frame_start = frame_start_q;
    assign bus.video_on    = video_on_q;
    assign bus.hsync       = hsync_q;
    assign bus.vsync       = vsync_q;
    assign bus.rgb_out     = rgb_out_q;

endmodule

`default_nettype wire

// File: tb/tb_vga_sync_gen.sv
`default_nettype none
// ============================================================================
// Module   : tb_vga_sync_gen
// Brief    : Scoreboard bench for vga_sync_gen: default 640x480 timing at
//            CLK_DIV=2 and a reduced 14x7 timing at CLK_DIV=4.
// Revision : 1.0 - initial release
// ============================================================================

module tb_vga_sync_gen;

    typedef struct packed {
        logic [10:0] x;
        logic [10:0] y;
        logic        video_on;
        logic        hsync;
        logic        vsync;
        logic [7:0]  rgb;
        logic        fs;
    } exp_t;

    logic       clk;
    logic [1:0] rst_n;
    logic [1:0] all_ff;
    logic       done;
    int         checks = 0;
    int         errors = 0;

    task automatic chk(input string name, input int g,
                       input logic [31:0] act, input logic [31:0] expv);
        checks++;
        if (act !== expv) begin
            errors++;
            $display("FAIL %s dut%0d: got %0h, expected %0h (t=%0t)",
                     name, g, act, expv, $time);
        end
    endtask

    initial clk = 1'b0;
    always #5 clk = ~clk;

    for (genvar G = 0; G < 2; G++) begin : g_dut
        localparam int D  = (G == 0) ? 2   : 4;
        localparam int HV = (G == 0) ? 640 : 8;
        localparam int HF = (G == 0) ? 16  : 2;
        localparam int HS = (G == 0) ? 96  : 2;
        localparam int HB = (G == 0) ? 48  : 2;
        localparam int VV = (G == 0) ? 480 : 4;
        localparam int VF = (G == 0) ? 10  : 1;
        localparam int VS = (G == 0) ? 2   : 1;
        localparam int VB = (G == 0) ? 33  : 1;
        localparam int HT = HV + HF + HS + HB;
        localparam int VT = VV + VF + VS + VB;
        localparam int FT = HT * VT;

        vga_sync_gen_if vif();

        vga_sync_gen #(
            .CLK_DIV  (D),
            .H_VISIBLE(HV), .H_FRONT(HF), .H_SYNC(HS), .H_BACK(HB),
            .V_VISIBLE(VV), .V_FRONT(VF), .V_SYNC(VS), .V_BACK(VB)
        ) u_dut (
            .clk  (clk),
            .rst_n(rst_n[G]),
            .bus  (vif)
        );

        exp_t        q[$];
        int          n = 0;
        int          s, p, pn;
        logic [10:0] mx = '0;
        logic [10:0] my = '0;
        logic [7:0]  rgb;
        logic        vis;
        logic        exp_pix;
        logic        prev_pix = 1'b0;
        int          fs_seen = 0;
        int          fs_exp = 0;
        exp_t        e;
        exp_t        g;

        // Stimulus: renderer colour from the bench position model, expected
        // pin/counter state pushed whenever the next edge is a strobe edge.
        always @(negedge clk) begin
            if (!rst_n[G]) begin
                n = 0;
                q.delete();
                vif.rgb_in = 8'h00;
            end else begin
                n++;
                s  = (n > D) ? (n - 1) / D : 0;
                p  = s % FT;
                mx = 11'(p % HT);
                my = 11'(p / HT);
                rgb = all_ff[G] ? 8'hFF : 8'(mx + my);
                vif.rgb_in = rgb;
                exp_pix = (n >= D) && (n % D == 0);
                chk("pix_en", G, 32'(vif.pix_en), 32'(exp_pix));
                if (exp_pix) begin
                    pn         = (p + 1) % FT;
                    vis        = (mx < HV) && (my < VV);
                    e.x        = 11'(pn % HT);
                    e.y        = 11'(pn / HT);
                    e.video_on = vis;
                    e.hsync    = !((mx >= HV + HF) && (mx < HV + HF + HS));
                    e.vsync    = !((my >= VV + VF) && (my < VV + VF + VS));
                    e.rgb      = vis ? rgb : 8'h00;
                    e.fs       = (pn == 0);
                    if (e.fs) fs_exp++;
                    q.push_back(e);
                end
            end
        end

        // Monitor: every DUT strobe is followed by an update to compare.
        always @(negedge clk) begin
            if (!rst_n[G]) begin
                prev_pix = 1'b0;
            end else begin
                if (vif.frame_start) fs_seen++;
                if (prev_pix) begin
                    if (q.size() == 0) begin
                        chk("sb_underflow", G, 32'(q.size()), 32'd1);
                    end else begin
                        g = q.pop_front();
                        chk("x",           G, 32'(vif.x),           32'(g.x));
                        chk("y",           G, 32'(vif.y),           32'(g.y));
                        chk("video_on",    G, 32'(vif.video_on),    32'(g.video_on));
                        chk("hsync",       G, 32'(vif.hsync),       32'(g.hsync));
                        chk("vsync",       G, 32'(vif.vsync),       32'(g.vsync));
                        chk("rgb_out",     G, 32'(vif.rgb_out),     32'(g.rgb));
                        chk("frame_start", G, 32'(vif.frame_start), 32'(g.fs));
                    end
                end else begin
                    chk("frame_start_idle", G, 32'(vif.frame_start), 32'd0);
                end
                prev_pix = vif.pix_en;
            end
        end

        // Reset must act without waiting for a clock edge.
        always @(negedge rst_n[G]) begin
            #1;
            chk("rst_x",           G, 32'(vif.x),           32'd0);
            chk("rst_y",           G, 32'(vif.y),           32'd0);
            chk("rst_pix_en",      G, 32'(vif.pix_en),      32'd0);
            chk("rst_frame_start", G, 32'(vif.frame_start), 32'd0);
            chk("rst_video_on",    G, 32'(vif.video_on),    32'd0);
            chk("rst_hsync",       G, 32'(vif.hsync),       32'd1);
            chk("rst_vsync",       G, 32'(vif.vsync),       32'd1);
            chk("rst_rgb_out",     G, 32'(vif.rgb_out),     32'd0);
        end

        always @(posedge done) begin
            chk("sb_drain",    G, 32'(q.size() <= 1), 32'd1);
            chk("frame_count", G, 32'(fs_seen),       32'(fs_exp));
        end
    end

    initial begin
        bit reached;
        rst_n  = 2'b11;
        all_ff = 2'b00;
        done   = 1'b0;
        #3 rst_n = 2'b00;
        repeat (2) @(negedge clk);
        #2 rst_n = 2'b11;

        // Two lines of the x+y colour pattern, then saturated colour across
        // a full line including the blanking region.
        repeat (3200) @(negedge clk);
        #1 all_ff[0] = 1'b1;
        repeat (1700) @(negedge clk);
        #1 all_ff[0] = 1'b0;

        reached = 1'b0;
        for (int k = 0; k < 4000; k++) begin
            if (g_dut[0].mx == 11'd300 && g_dut[0].my == 11'd3) begin
                reached = 1'b1;
                break;
            end
            @(negedge clk);
            #1;
        end
        chk("reach_mid_frame", 0, 32'(reached), 32'd1);

        // Asynchronous reset in the middle of a line and a pixel period.
        @(posedge clk);
        #3 rst_n[0] = 1'b0;
        repeat (3) @(negedge clk);
        #2 rst_n[0] = 1'b1;
        repeat (3300) @(negedge clk);

        #1 done = 1'b1;
        #1;
        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule

`default_nettype wire
